// File: rtl/fsubnorm_seq.sv
// fsubnorm_seq: sequential operand normalizer for the FPU unpack path.
// Takes a biased exponent and a left-aligned fraction. Returns an unbiased signed
// exponent and a mantissa with the leading one at bit NF.
// Normal and zero operands finish in one cycle. Subnormals shift one bit per cycle.
// Optional feature macro: FSUBNORM_DUAL_SHIFT_EN lets SHIFT move two bits per cycle.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for an operand; InReady=1
// SHIFT | subnormal being normalized, UExp decremented per bit moved
// DONE  | result valid, held until OutReady
module fsubnorm_seq #(
    parameter int NE      = 11,
    parameter int NF      = 52,
    parameter int LOGFLEN = 6,
    parameter int FMTBITS = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [FMTBITS-1:0]   Fmt,
    input  logic [NE-2:0]        Bias,
    input  logic [LOGFLEN-1:0]   Nf,
    input  logic [NE-1:0]        Exp,
    input  logic [NF-1:0]        Frac,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [FMTBITS-1:0]   FmtOut,
    output logic signed [NE+1:0] UExp,
    output logic [NF:0]          Mant,
    output logic                 Zero
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [NF-1:0]        FRAC_ONES = '1;
    localparam logic signed [NE+1:0] UEXP_ONE  = (NE+2)'(1);
`ifdef FSUBNORM_DUAL_SHIFT_EN
    localparam logic signed [NE+1:0] UEXP_TWO  = (NE+2)'(2);
`endif

    state_t              state_q, state_d;
    logic signed [NE+1:0] uexp_q, uexp_d;
    logic [NF:0]         mant_q, mant_d;
    logic                zero_q, zero_d;
    logic [FMTBITS-1:0]  fmt_q, fmt_d;

    logic [NF-1:0]       frac_keep;
    logic [NF-1:0]       frac_m;
    logic [NE+1:0]       exp_ext;
    logic [NE+1:0]       bias_ext;

    // Fraction mask keeps only the top Nf bits; operand exponent/bias widened for signed math
    always_comb begin
        frac_keep = ~(FRAC_ONES >> Nf);
        frac_m    = Frac & frac_keep;
        exp_ext   = {2'b00, Exp};
        bias_ext  = {3'b000, Bias};
    end

    // Next-state and datapath update: classify on accept, shift in SHIFT, hold in DONE
    always_comb begin
        state_d = state_q;
        uexp_d  = uexp_q;
        mant_d  = mant_q;
        zero_d  = zero_q;
        fmt_d   = fmt_q;
        case (state_q)
            S_IDLE: begin
                if (InValid) begin
                    fmt_d = Fmt;
                    if (Exp != '0) begin
                        uexp_d  = $signed(exp_ext - bias_ext);
                        mant_d  = {1'b1, frac_m};
                        zero_d  = 1'b0;
                        state_d = S_DONE;
                    end else if (frac_m == '0) begin
                        uexp_d  = '0;
                        mant_d  = '0;
                        zero_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        uexp_d  = UEXP_ONE - $signed(bias_ext);
                        mant_d  = {1'b0, frac_m};
                        zero_d  = 1'b0;
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
`ifdef FSUBNORM_DUAL_SHIFT_EN
                if (mant_q[NF-1]) begin
                    mant_d  = mant_q << 1;
                    uexp_d  = uexp_q - UEXP_ONE;
                    state_d = S_DONE;
                end else begin
                    mant_d = mant_q << 2;
                    uexp_d = uexp_q - UEXP_TWO;
                    if (mant_q[NF-2]) begin
                        state_d = S_DONE;
                    end
                end
`else
                mant_d = mant_q << 1;
                uexp_d = uexp_q - UEXP_ONE;
                if (mant_q[NF-1]) begin
                    state_d = S_DONE;
                end
`endif
            end
            S_DONE: begin
                if (OutReady) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers; reset drops any in-flight operand
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            uexp_q  <= '0;
            mant_q  <= '0;
            zero_q  <= 1'b0;
            fmt_q   <= '0;
        end else begin
            state_q <= state_d;
            uexp_q  <= uexp_d;
            mant_q  <= mant_d;
            zero_q  <= zero_d;
            fmt_q   <= fmt_d;
        end
    end

    // Handshake and result outputs straight from the registers
    always_comb begin
        InReady  = (state_q == S_IDLE);
        OutValid = (state_q == S_DONE);
        UExp     = uexp_q;
        Mant     = mant_q;
        Zero     = zero_q;
        FmtOut   = fmt_q;
    end

endmodule
